pipelined_cla_adder: RTL
========================

# pipelined_cla_adder

- Parametrised, pipelined carry-lookahead adder: adds two WIDTH-bit operands plus a carry-in and returns the WIDTH-bit sum and carry-out.
- The operand is split into GROUP-bit lookahead groups, and one group is resolved per pipeline stage, so full throughput is kept at any width.
- A valid/ready handshake on both sides lets it sit between streaming datapath blocks.

## Interface
Parameters:
- WIDTH, 16, operand and sum width; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group (one pipeline stage each).
- NSTAGE, WIDTH/GROUP, derived local constant: pipeline depth.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with CLA_OVERFLOW_EN.

## Operation
- Stage k (k = 1..NSTAGE) computes sum bits [k*GROUP-1 : (k-1)*GROUP] with a GROUP-bit lookahead group.
- Carry input: cin for stage 1; the registered group carry of stage k-1 otherwise.
- Unprocessed upper operand bits and already-computed lower sum bits travel alongside in per-stage registers. Each stage has its own valid bit.
- Advance condition: `advance = !out_valid || out_ready`. When advance is 1, every stage register loads from its predecessor. When it is 0, the whole pipe holds.
- `in_ready = advance`. This is a combinational path from out_ready.
- Transfer rules:
  - Input transfer happens when in_valid && in_ready.
  - If in_valid is 0 during an advance, stage 1 loads a bubble (valid 0).
  - Output transfer happens when out_valid && out_ready.
- Ordering: results emerge in acceptance order. No drops, no duplicates.
- Width rule: sum = (a + b + cin) mod 2^WIDTH, and cout = bit WIDTH of the full (WIDTH+1)-bit result.
- Boundary cases:
  - a = all-ones, b = 0, cin = 1 gives sum = 0, cout = 1. The carry propagates through every stage.
  - cin is honoured when a = b = 0.
- Producer rule: while in_valid is high and in_ready is low, a/b/cin must stay stable and in_valid must stay asserted.
- Consumer rule: while out_valid is high and out_ready is low, sum/cout/ovf are held stable.
- Reset (rst_n low at an edge) clears every stage valid bit and every data register, including mid-operation. In-flight results are discarded.

## Timing
- Reset values: out_valid 0, sum 0, cout 0, ovf 0. in_ready is 1 on the first cycle after reset.
- Latency: operands accepted at edge t produce out_valid = 1 after edge t+NSTAGE-1, provided there is no stall. That is 4 edges for the defaults, and 1 edge when NSTAGE = 1.
- Throughput: one result per cycle while out_ready is held high.
- Stall cycles add latency one-for-one.
- Simultaneous input accept and output transfer in the same cycle is legal and is the steady state.

## Configuration
- CLA_OVERFLOW_EN defined:
  - ovf port exists.
  - ovf = carry into bit WIDTH-1 XOR cout, carried down the pipe with its result and held during stalls.
  - ovf resets to 0.
- CLA_OVERFLOW_EN undefined:
  - No ovf port and no associated registers.
  - All other behaviour is identical.

## Structure
- Shared package cla_pkg holds:
  - the default WIDTH/GROUP constants;
  - a function computing NSTAGE;
  - a typedef for the group propagate/generate pair.
- One sub-module, cla_group: combinational GROUP-bit lookahead adder with inputs a, b, cin and outputs s, cout, group P, group G.
- NSTAGE instances of cla_group are generated, one per stage.
- Elaboration-time check: WIDTH % GROUP == 0 and GROUP >= 1.

## Test plan
Defaults WIDTH=16, GROUP=4.
1. Reset: hold rst_n low 2 cycles with in_valid = 1 → out_valid 0, sum 0x0000, cout 0 throughout. in_ready = 1 after release.
2. Single op: a=0x0001, b=0x0000, cin=0 → exactly 4 edges later out_valid = 1, sum 0x0001, cout 0.
3. Full ripple: a=0xFFFF, b=0x0000, cin=1 → sum 0x0000, cout 1. Also 0x000B+0x0006+0 → 0x0011, and 0x0005+0x0003+1 → 0x0009.
4. Stream with backpressure: push 8 consecutive ops (a=i, b=0x1000, cin=0, i=0..7). Drop out_ready for 3 cycles mid-stream → in_ready low for those cycles, sum held stable, and outputs 0x1000..0x1007 arrive in order, each exactly once.
5. Reset mid-operation: accept 3 ops, then assert rst_n low for one edge → out_valid 0 next cycle and no stale result ever emerges.
6. With CLA_OVERFLOW_EN: 0x7FFF+0x0001 → sum 0x8000, cout 0, ovf 1. 0x8000+0x8000 → sum 0x0000, cout 1, ovf 1. 0xFFFF+0x0001 → sum 0x0000, cout 1, ovf 0.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, depth function and propagate/generate type for the pipelined CLA adder
package cla_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_GROUP = 4;
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;
    function automatic int nstage(input int width, input int group);
        return (group > 0) ? width / group : 1;
    endfunction
endpackage

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit carry-lookahead adder with group propagate/generate
module cla_group import cla_pkg::*; #(
    parameter int GROUP = DEF_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             p,
    output logic             g
);
    logic [GROUP-1:0] pi, gi;
    logic [GROUP:0] c;
    logic gacc, pacc;
    assign pi = a ^ b;
    assign gi = a & b;
    assign p = &pi;
    assign s = pi ^ c[GROUP-1:0];
    assign cout = c[GROUP];
    // every carry is a flat sum-of-products over the bit generates/propagates below it
    always_comb begin
        c = '0;
        c[0] = cin;
        g = 1'b0;
        gacc = 1'b0;
        pacc = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            gacc = gi[i];
            pacc = pi[i];
            for (int j = i - 1; j >= 0; j--) begin
                gacc = gacc | (pacc & gi[j]);
                pacc = pacc & pi[j];
            end
            c[i+1] = gacc | (pacc & cin);
            g = gacc;
        end
    end
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: one lookahead group per stage with valid/ready flow control.
// Optional CLA_OVERFLOW_EN adds the registered signed-overflow output ovf.
module pipelined_cla_adder import cla_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int NSTAGE = nstage(WIDTH, GROUP);
    localparam int UP = WIDTH - GROUP;

    if (GROUP < 1 || WIDTH % GROUP != 0) begin : g_bad
        $error("WIDTH must be a non-zero multiple of GROUP");
    end

    logic adv;
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;

    // xq rotates right by one group per stage: unused A bits drain out the bottom
    // while finished sum groups enter at the top, so the last stage holds the sum
    genvar k;
    for (k = 0; k < NSTAGE; k++) begin : st
        localparam int YI = WIDTH - k * GROUP;
        logic [WIDTH-1:0] xi, xq;
        logic [YI-1:0] yi;
        logic ci, vi, co, cn, cq, vq;
        logic [GROUP-1:0] gs;
        pg_t pg;
        if (k == 0) begin : g_src
            assign xi = a;
            assign yi = b;
            assign ci = cin;
            assign vi = in_valid;
        end else begin : g_src
            assign xi = st[k-1].xq;
            assign yi = st[k-1].g_y.yq;
            assign ci = st[k-1].cq;
            assign vi = st[k-1].vq;
        end
        cla_group #(.GROUP(GROUP)) u_grp (
            .a(xi[GROUP-1:0]),
            .b(yi[GROUP-1:0]),
            .cin(ci),
            .s(gs),
            .cout(co),
            .p(pg.p),
            .g(pg.g)
        );
        assign cn = pg.g | (pg.p & ci);
        always_comb assert (co == cn);
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                xq <= '0;
                cq <= 1'b0;
                vq <= 1'b0;
            end else if (adv) begin
                xq <= (xi >> GROUP) | (WIDTH'(gs) << UP);
                cq <= cn;
                vq <= vi;
            end
        end
        // B shrinks by one group per stage; nothing of it is left after the last
        if (k < NSTAGE - 1) begin : g_y
            logic [YI-GROUP-1:0] yq;
            always_ff @(posedge clk) begin
                if (!rst_n) yq <= '0;
                else if (adv) yq <= yi[YI-1:GROUP];
            end
        end
`ifdef CLA_OVERFLOW_EN
        if (k == NSTAGE - 1) begin : g_ovf
            logic oq;
            always_ff @(posedge clk) begin
                if (!rst_n) oq <= 1'b0;
                else if (adv) oq <= gs[GROUP-1] ^ xi[GROUP-1] ^ yi[GROUP-1] ^ cn;
            end
        end
`endif
    end

    assign sum = st[NSTAGE-1].xq;
    assign cout = st[NSTAGE-1].cq;
    assign out_valid = st[NSTAGE-1].vq;
`ifdef CLA_OVERFLOW_EN
    assign ovf = st[NSTAGE-1].g_ovf.oq;
`endif
endmodule
